// File: rtl/vga_text_vram_sequencer.sv
// Bulk VRAM engine for the VGA text controller: CLEAR, FILL_ROW and SCROLL_UP as an Avalon-MM master.
// Optional macro VGA_TEXT_SEQ_VSYNC_WAIT_EN holds each command in ARM until a vsync falling edge.
`timescale 1ns/1ps
module vga_text_vram_sequencer #(
  parameter int ROWS          = 30,
  parameter int WORDS_PER_ROW = 20,
  parameter int READ_LATENCY  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_row,
  input  logic [31:0] cmd_fill,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        vs,
  output logic [11:0] M_ADDR,
  output logic        M_READ,
  output logic        M_WRITE,
  output logic        M_CS,
  output logic [3:0]  M_BYTE_EN,
  output logic [31:0] M_WRITEDATA,
  input  logic [31:0] M_READDATA,
  input  logic        M_WAITREQUEST
);
  localparam int TOTAL = ROWS * WORDS_PER_ROW;
  localparam int CW    = $clog2(TOTAL);
  localparam int LW    = $clog2(READ_LATENCY + 1);

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_SCROLL = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;

  localparam logic [CW-1:0] LAST_WORD   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SCROLL_LAST = CW'((ROWS - 1) * WORDS_PER_ROW - 1);

  typedef enum logic [2:0] {IDLE, ARM, RD_REQ, RD_WAIT, WR, FILL, DONE} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [4:0]    row_q;
  logic [31:0]   fill_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [LW-1:0] lat;

  logic          accept;
  logic          bad_cmd;
  logic          go;
  logic [1:0]    l_op;
  logic [4:0]    l_row;
  logic [31:0]   l_fill;
  logic [CW-1:0] fill_start;
  logic [CW-1:0] fill_last;
  logic [CW-1:0] cnt_nxt;
  logic [11:0]   rd_nxt;

  assign M_BYTE_EN = 4'hF;

  // Launch parameters come straight from the command port in IDLE, from the latched copy in ARM.
  always_comb begin
    accept     = cmd_valid & cmd_ready;
    bad_cmd    = (cmd_op == 2'b11) | ((cmd_op == OP_FILL) & (int'(cmd_row) >= ROWS));
    l_op       = (state == IDLE) ? cmd_op   : op_q;
    l_row      = (state == IDLE) ? cmd_row  : row_q;
    l_fill     = (state == IDLE) ? cmd_fill : fill_q;
    fill_start = '0;
    fill_last  = LAST_WORD;
    if (l_op == OP_FILL) begin
      fill_start = CW'(int'(l_row) * WORDS_PER_ROW);
      fill_last  = fill_start + CW'(WORDS_PER_ROW - 1);
    end
    cnt_nxt    = cnt + 1'b1;
    rd_nxt     = 12'(cnt_nxt) + 12'(WORDS_PER_ROW);
  end

`ifdef VGA_TEXT_SEQ_VSYNC_WAIT_EN
  logic vs_q;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) vs_q <= 1'b1;
    else       vs_q <= vs;
  end
  assign go = (state == ARM) & vs_q & ~vs;
`else
  logic unused_vs;
  assign unused_vs = vs;
  assign go = (state == IDLE) & accept & ~bad_cmd;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_CS        <= 1'b0;
      M_ADDR      <= '0;
      M_WRITEDATA <= '0;
      op_q        <= '0;
      row_q       <= '0;
      fill_q      <= '0;
      cnt         <= '0;
      last        <= '0;
      lat         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            row_q     <= cmd_row;
            fill_q    <= cmd_fill;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            if (bad_cmd) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= ARM;
            end
          end
        end
        ARM: ;
        FILL: begin
          if (!M_WAITREQUEST) begin
            if (cnt == last) begin
              M_WRITE <= 1'b0;
              M_CS    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              cnt    <= cnt_nxt;
              M_ADDR <= 12'(cnt_nxt);
            end
          end
        end
        RD_REQ: begin
          if (!M_WAITREQUEST) begin
            M_READ <= 1'b0;
            M_CS   <= 1'b0;
            lat    <= LW'(1);
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat == LW'(READ_LATENCY)) begin
            M_WRITEDATA <= M_READDATA;
            M_WRITE     <= 1'b1;
            M_CS        <= 1'b1;
            M_ADDR      <= 12'(cnt);
            state       <= WR;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        WR: begin
          if (!M_WAITREQUEST) begin
            cnt <= cnt_nxt;
            if (cnt == SCROLL_LAST) begin
              // Copy finished: the write strobe stays up and rolls straight into the last-row fill.
              M_ADDR      <= 12'(cnt_nxt);
              M_WRITEDATA <= fill_q;
              last        <= LAST_WORD;
              state       <= FILL;
            end else begin
              M_WRITE <= 1'b0;
              M_READ  <= 1'b1;
              M_ADDR  <= rd_nxt;
              state   <= RD_REQ;
            end
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (go) begin
        busy <= 1'b1;
        M_CS <= 1'b1;
        if (l_op == OP_SCROLL) begin
          M_READ  <= 1'b1;
          M_WRITE <= 1'b0;
          M_ADDR  <= 12'(WORDS_PER_ROW);
          cnt     <= '0;
          state   <= RD_REQ;
        end else begin
          M_READ      <= 1'b0;
          M_WRITE     <= 1'b1;
          M_ADDR      <= 12'(fill_start);
          M_WRITEDATA <= l_fill;
          cnt         <= fill_start;
          last        <= fill_last;
          state       <= FILL;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_text_vram_sequencer.sv
// Self-checking bench: table of commands, hand sequences (cmd_valid while busy, reset mid-CLEAR) and random commands against a VRAM model.
`timescale 1ns/1ps
module tb_vga_text_vram_sequencer;
  localparam int ROWS = 30, WPR = 20, LAT = 2, TOTAL = ROWS * WPR, LIMIT = 20000;

  logic        CLK = 1'b0, RESET = 1'b0, cmd_valid = 1'b0, vs = 1'b1;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_row = '0;
  logic [31:0] cmd_fill = '0;
  logic [31:0] M_READDATA;
  logic        M_WAITREQUEST = 1'b0;
  logic        cmd_ready, busy, done, err, M_READ, M_WRITE, M_CS;
  logic [11:0] M_ADDR;
  logic [3:0]  M_BYTE_EN;
  logic [31:0] M_WRITEDATA;

  vga_text_vram_sequencer #(.ROWS(ROWS), .WORDS_PER_ROW(WPR), .READ_LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_fill(cmd_fill), .busy(busy), .done(done), .err(err), .vs(vs),
    .M_ADDR(M_ADDR), .M_READ(M_READ), .M_WRITE(M_WRITE), .M_CS(M_CS), .M_BYTE_EN(M_BYTE_EN),
    .M_WRITEDATA(M_WRITEDATA), .M_READDATA(M_READDATA), .M_WAITREQUEST(M_WAITREQUEST)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  int checks = 0, failures = 0;
  int unsigned wr_log[$];
  int rd_total = 0, viol = 0, busy_total = 0, rd_cnt = 0, preload_mode = 0;
  logic [31:0] rd_dat;
  bit rand_wait = 0;
  bit prev_stall;
  logic prev_rd, prev_wr;
  logic [11:0] prev_addr;
  logic [31:0] prev_wd;

  // Avalon slave with fixed read latency plus protocol monitor.
  always @(posedge CLK) begin
    if (preload_mode == 1) for (int a = 0; a < 4096; a++) mem[a] = '0;
    else if (preload_mode == 2) for (int a = 0; a < 4096; a++) mem[a] = (a < TOTAL) ? {4{8'(a / WPR)}} : 32'h0;
    if (RESET) begin
      rd_cnt = 0;
      prev_stall = 0;
    end else begin
      if (busy) busy_total++;
      if (M_CS !== (M_READ | M_WRITE)) viol++;
      if (M_READ && M_WRITE) viol++;
      if (prev_stall && (M_READ !== prev_rd || M_WRITE !== prev_wr || M_ADDR !== prev_addr ||
                         (prev_wr && M_WRITEDATA !== prev_wd))) viol++;
      if (M_WRITE && !M_WAITREQUEST) begin
        mem[M_ADDR] = M_WRITEDATA;
        wr_log.push_back(32'(M_ADDR));
      end
      if (M_READ && !M_WAITREQUEST) begin
        if (rd_cnt > 0) viol++;
        if (int'(M_ADDR) >= TOTAL) viol++;
        rd_total++;
        rd_cnt = LAT;
        rd_dat = mem[M_ADDR];
      end else if (rd_cnt > 0) rd_cnt--;
      prev_stall = (M_READ || M_WRITE) && M_WAITREQUEST;
      prev_rd = M_READ; prev_wr = M_WRITE; prev_addr = M_ADDR; prev_wd = M_WRITEDATA;
    end
  end

  // Read data is valid only in the READ_LATENCY-th cycle after acceptance.
  always @(negedge CLK) begin
    M_READDATA    = (rd_cnt == 1) ? rd_dat : 32'hDEADBEEF;
    M_WAITREQUEST = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void ref_apply(input logic [1:0] op, input logic [4:0] row, input logic [31:0] fill);
    case (op)
      2'd0: for (int a = 0; a < TOTAL; a++) ref_mem[a] = fill;
      2'd1: begin
        for (int a = 0; a < TOTAL - WPR; a++) ref_mem[a] = ref_mem[a + WPR];
        for (int a = TOTAL - WPR; a < TOTAL; a++) ref_mem[a] = fill;
      end
      2'd2: if (int'(row) < ROWS) for (int w = 0; w < WPR; w++) ref_mem[int'(row) * WPR + w] = fill;
      default: ;
    endcase
  endfunction

  function automatic void model_exp(input logic [1:0] op, input logic [4:0] row,
                                    output int w, output int r, output int lo, output int hi);
    w = 0; r = 0; lo = 0; hi = TOTAL - 1;
    if (op == 2'd0) w = TOTAL;
    else if (op == 2'd1) begin w = TOTAL; r = TOTAL - WPR; end
    else if (op == 2'd2 && int'(row) < ROWS) begin w = WPR; lo = int'(row) * WPR; hi = lo + WPR - 1; end
  endfunction

  function automatic int cycles_for(input logic [1:0] op, input logic [4:0] row);
    if (op == 2'd3 || (op == 2'd2 && int'(row) >= ROWS)) return 1;
    if (op == 2'd0) return TOTAL + 1;
    if (op == 2'd2) return WPR + 1;
    return (TOTAL - WPR) * (LAT + 2) + WPR + 1;
  endfunction

  task automatic vram_compare(input string name);
    int bad = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== ref_mem[a]) bad++;
    check(name, bad, 0);
  endtask

  task automatic preload(input int m);
    for (int a = 0; a < 4096; a++) ref_mem[a] = (m == 2 && a < TOTAL) ? {4{8'(a / WPR)}} : 32'h0;
    preload_mode = m;
    @(posedge CLK);
    #1 preload_mode = 0;
    @(negedge CLK);
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [4:0] row, input logic [31:0] fill);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge CLK); n++; end
    check("start.ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_fill = fill;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] row, input logic [31:0] fill,
                         input logic exp_err, input int exp_cycles, input string name);
    int sw, sr, sv, sb, k, w, r, lo, hi, mn, mx;
    logic b1, cs1, rdy1;
    model_exp(op, row, w, r, lo, hi);
    ref_apply(op, row, fill);
    sw = wr_log.size(); sr = rd_total; sv = viol; sb = busy_total;
    start_cmd(op, row, fill);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (k == 1) begin b1 = busy; cs1 = M_CS; rdy1 = cmd_ready; end
    end while (!done && k < LIMIT);
    check({name, ".done_seen"}, done, 1'b1);
    if (exp_cycles >= 0) begin
      check({name, ".cycles"}, k, exp_cycles);
      check({name, ".busy_cycles"}, busy_total - sb, exp_cycles - 1);
    end
    check({name, ".ready_c1"}, rdy1, 1'b0);
    check({name, ".busy_c1"}, b1, !exp_err);
    check({name, ".strobe_c1"}, cs1, !exp_err);
    check({name, ".err"}, err, exp_err);
    check({name, ".writes"}, wr_log.size() - sw, w);
    check({name, ".reads"}, rd_total - sr, r);
    check({name, ".protocol"}, viol - sv, 0);
    if (w > 0) begin
      mn = 4096; mx = -1;
      for (int i = sw; i < wr_log.size(); i++) begin
        if (int'(wr_log[i]) < mn) mn = int'(wr_log[i]);
        if (int'(wr_log[i]) > mx) mx = int'(wr_log[i]);
      end
      check({name, ".lo_addr"}, mn, lo);
      check({name, ".hi_addr"}, mx, hi);
    end
    vram_compare({name, ".vram"});
    @(negedge CLK);
    check({name, ".done_pulse"}, done, 1'b0);
    check({name, ".ready_after"}, cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  row;
    logic [31:0] fill;
    bit          rnd_wait;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int sw, k;
    logic [1:0] rop; logic [4:0] rrow; logic [31:0] rfill; bit rw;

    vecs[0] = '{2'd0, 5'd0,  32'h20202020, 1'b0, 1'b0, 601};
    vecs[1] = '{2'd2, 5'd5,  32'hAABBCCDD, 1'b0, 1'b0, 21};
    vecs[2] = '{2'd2, 5'd30, 32'h99999999, 1'b0, 1'b1, 1};
    vecs[3] = '{2'd2, 5'd0,  32'h12345678, 1'b0, 1'b0, 21};
    vecs[4] = '{2'd2, 5'd29, 32'hCAFEF00D, 1'b0, 1'b0, 21};
    vecs[5] = '{2'd3, 5'd0,  32'h77777777, 1'b0, 1'b1, 1};
    vecs[6] = '{2'd2, 5'd31, 32'h55555555, 1'b0, 1'b1, 1};
    vecs[7] = '{2'd1, 5'd0,  32'h00000000, 1'b0, 1'b0, 2341};
    vecs[8] = '{2'd0, 5'd0,  32'h0F0F0F0F, 1'b1, 1'b0, -1};

    #1 RESET = 1'b1;
    preload(1);
    check("rst.cmd_ready", cmd_ready, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.strobes", {M_READ, M_WRITE, M_CS}, 3'b000);
    check("rst.addr", M_ADDR, 12'h000);
    check("rst.wdata", M_WRITEDATA, 32'h0);
    check("rst.byte_en", M_BYTE_EN, 4'hF);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      rand_wait = vecs[i].rnd_wait;
      run_cmd(vecs[i].op, vecs[i].row, vecs[i].fill, vecs[i].exp_err, vecs[i].exp_cycles, $sformatf("vec%0d", i));
      rand_wait = 0;
    end

    preload(2);
    run_cmd(2'd1, 5'd0, 32'h0, 1'b0, 2341, "scroll");
    check("scroll.addr0", mem[0], 32'h01010101);
    check("scroll.addr560", mem[560], 32'h1D1D1D1D);
    check("scroll.addr580", mem[580], 32'h0);
    check("scroll.addr599", mem[599], 32'h0);
    preload(2);
    rand_wait = 1;
    run_cmd(2'd1, 5'd0, 32'h0, 1'b0, -1, "scroll_stall");
    rand_wait = 0;
    check("scroll_stall.addr0", mem[0], 32'h01010101);
    check("scroll_stall.addr560", mem[560], 32'h1D1D1D1D);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3)); rrow = 5'($urandom_range(0, 31)); rfill = $urandom; rw = 1'($urandom_range(0, 1));
      rand_wait = rw;
      run_cmd(rop, rrow, rfill, (rop == 2'd3) || (rop == 2'd2 && int'(rrow) >= ROWS),
              rw ? -1 : cycles_for(rop, rrow), $sformatf("rnd%0d", i));
      rand_wait = 0;
    end

    // cmd_valid while busy must be dropped, not queued.
    ref_apply(2'd0, 5'd0, 32'h5A5A5A5A);
    sw = wr_log.size();
    start_cmd(2'd0, 5'd0, 32'h5A5A5A5A);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (k == 100) begin cmd_valid = 1'b1; cmd_op = 2'd2; cmd_row = 5'd3; cmd_fill = 32'hDEADDEAD; end
      if (k == 101) begin check("busyvalid.ready", cmd_ready, 1'b0); cmd_valid = 1'b0; end
    end while (!done && k < LIMIT);
    check("busyvalid.cycles", k, 601);
    check("busyvalid.writes", wr_log.size() - sw, TOTAL);
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("busyvalid.no_queue", busy, 1'b0);
    vram_compare("busyvalid.vram");

    // Reset mid-CLEAR.
    sw = wr_log.size();
    start_cmd(2'd0, 5'd0, 32'h11111111);
    k = 0;
    while (wr_log.size() - sw < 300 && k < LIMIT) begin @(negedge CLK); k++; end
    check("midrst.reached300", (wr_log.size() - sw >= 300), 1'b1);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("midrst.strobes", {M_READ, M_WRITE, M_CS}, 3'b000);
    check("midrst.busy", busy, 1'b0);
    check("midrst.ready", cmd_ready, 1'b1);
    check("midrst.addr", M_ADDR, 12'h000);
    check("midrst.wdata", M_WRITEDATA, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    run_cmd(2'd0, 5'd0, 32'h22222222, 1'b0, 601, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
